edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of monitored input lines (legal range 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 a_i  input  NUM_CH  SHALL carry the monitored levels, already synchronous to clk.
REQ-005 en_i  input  1  SHALL gate capture of new edges (1 = capture).
REQ-006 evt_valid_o  output  1  SHALL flag that an event is presented.
REQ-007 evt_ready_i  input  1  SHALL flag that the consumer accepts the event.
REQ-008 evt_ch_o  output  $clog2(NUM_CH)  SHALL give the channel index of the presented event.
REQ-009 evt_rise_o  output  1  SHALL give the event type (1 = rising, 0 = falling).
REQ-010 pending_o  output  NUM_CH  SHALL flag channels holding any undelivered event.
REQ-011 overflow_o  output  NUM_CH  SHALL carry sticky per-channel lost-event flags.
REQ-012 ovf_clr_i  input  1  SHALL clear all overflow_o bits.

Function
REQ-013 Each channel SHALL register prev = a_i every cycle; rise = a_i & ~prev, fall = ~a_i & prev.
REQ-014 Edge detection SHALL be masked for the first cycle after reset deassertion, so a static level held through reset produces no event.
REQ-015 A detected edge with en_i=1 at posedge k SHALL set that channel's rise- or fall-pending bit at posedge k; with en_i=0 the edge is discarded while prev still tracks.
REQ-016 Each channel SHALL keep an order bit marking which pending type was set first; when both are pending, the older type is granted first.
REQ-017 The output register SHALL load when evt_valid_o=0 or (evt_valid_o & evt_ready_i), and some channel is pending.
REQ-018 Channel selection SHALL be round-robin: search starts at pointer ptr; after granting channel c, ptr = (c+1) mod NUM_CH.
REQ-019 Loading an event SHALL clear the granted pending bit in the same cycle; minimum latency is edge at posedge k to evt_valid_o high after posedge k+1.
REQ-020 evt_valid_o, evt_ch_o and evt_rise_o SHALL remain stable while evt_valid_o=1 and evt_ready_i=0.
REQ-021 With evt_ready_i held high, throughput SHALL be one event per cycle.
REQ-022 A new edge of a type whose pending bit is set and not being cleared that cycle SHALL be merged and SHALL set overflow_o for that channel.
REQ-023 A new edge coinciding with the clear of the same pending bit SHALL leave the bit set, with no overflow.
REQ-024 ovf_clr_i SHALL clear overflow_o; a new overflow in the same cycle SHALL win (bit remains 1).
REQ-025 pending_o[c] SHALL equal rise_pend[c] | fall_pend[c], registered.

Reset
REQ-026 Reset SHALL asynchronously force evt_valid_o, evt_ch_o, evt_rise_o, pending_o, overflow_o, all prev, order bits and ptr to 0, and the arm flag to 0.
REQ-027 Reset asserted mid-transfer SHALL drop evt_valid_o immediately and discard all pending events.

Structure
REQ-028 Package edge_evt_pkg SHALL hold the NUM_CH default and the typedef evt_t {ch index, rise bit}.
REQ-029 Sub-module edge_detect (prev register plus rise and fall pulses, one instance per channel) SHALL be used.

Verification (NUM_CH=4)
REQ-030 a_i=4'b1111 during reset, then held constant -> evt_valid_o=0 and pending_o=0 for 5 cycles.
REQ-031 ch2 rises before posedge 10, ready=1 -> after posedge 11: valid=1, ch=2, rise=1 for exactly one cycle.
REQ-032 all four channels rise in the same cycle, ptr=0, ready=1 -> channels 0,1,2,3 granted on consecutive cycles, then valid=0.
REQ-033 ready=0, ch1 sequence rise, fall, rise, fall -> output holds ch1 rise; overflow_o[1]=1 after the second fall; ready=1 -> ch1 fall then ch1 rise.
REQ-034 ovf_clr_i=1 in the same cycle as a new ch3 overflow -> overflow_o[3] stays 1; ovf_clr_i alone -> overflow_o=0.
REQ-035 reset pulsed while valid=1 with 3 events pending -> valid=0 and pending_o=0 with no clock edge; no events after release.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
// The event channel field is sized for the largest legal channel count.
package edge_evt_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_MAX   = 4;

  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic                rise;
  } evt_t;

  // Round-robin successor of channel c in a ring of n channels.
  function automatic int wrap_inc(input int c, input int n);
    return (c + 1 >= n) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One monitored line: previous-level register plus rise/fall pulses.
// Pulses are suppressed while arm is low so a level held through reset is silent.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic arm,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= a;
  end

  assign rise = arm & a & ~prev;
  assign fall = arm & ~a & prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising/falling edges on NUM_CH lines and delivers them one at a
// time, round-robin across channels, oldest type first within a channel.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  input  logic              en_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CW-1:0]     evt_ch_o,
  output logic              evt_rise_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overflow_o,
  input  logic              ovf_clr_i
);

  // Handshake: an event transfers on a posedge where evt_valid_o and
  // evt_ready_i are both high; while valid is high and ready low the
  // presented event (valid, ch, rise) is held unchanged.

  logic              arm;
  logic [NUM_CH-1:0] rise, fall;
  logic [NUM_CH-1:0] rise_pend, fall_pend, ord, ovf;
  logic [CW-1:0]     ptr;
  evt_t              evt_q;
  logic              valid_q;

  logic              load;
  logic              sel_found;
  logic [CW-1:0]     sel_ch;
  logic              sel_rise;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     ptr_n;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] cap_r, cap_f, keep_r, keep_f;
  logic [NUM_CH-1:0] rise_pend_n, fall_pend_n, ord_n, ovf_new;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_det
    edge_detect u_det (
      .clk   (clk),
      .reset (reset),
      .a     (a_i[g]),
      .arm   (arm),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) arm <= 1'b0;
    else       arm <= 1'b1;
  end

  // Round-robin search from ptr; within a channel the older type wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_rise  = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CW'((int'(ptr) + i) % NUM_CH);
      if (!sel_found && (rise_pend[idx] || fall_pend[idx])) begin
        sel_found = 1'b1;
        sel_ch    = idx;
        sel_rise  = rise_pend[idx] & (~fall_pend[idx] | ord[idx]);
      end
    end
  end

  always_comb begin
    load     = (~valid_q | evt_ready_i) & sel_found;
    grant_oh = load ? (NUM_CH'(1) << sel_ch) : '0;
    ptr_n    = CW'(wrap_inc(int'(sel_ch), NUM_CH));

    cap_r  = rise & {NUM_CH{en_i}};
    cap_f  = fall & {NUM_CH{en_i}};
    keep_r = rise_pend & ~(grant_oh & {NUM_CH{sel_rise}});
    keep_f = fall_pend & ~(grant_oh & {NUM_CH{~sel_rise}});

    rise_pend_n = keep_r | cap_r;
    fall_pend_n = keep_f | cap_f;
    // An edge landing on a still-held bit of its type is merged and lost.
    ovf_new     = (cap_r & keep_r) | (cap_f & keep_f);

    // ord=1: rise is older. A fresh type joining a held one becomes the newer.
    ord_n = (ord & ~(cap_r & ~keep_r & keep_f)) | (cap_f & ~keep_f & keep_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_pend <= '0;
      fall_pend <= '0;
      ord       <= '0;
      ovf       <= '0;
    end else begin
      rise_pend <= rise_pend_n;
      fall_pend <= fall_pend_n;
      ord       <= ord_n;
      ovf       <= (ovf & ~{NUM_CH{ovf_clr_i}}) | ovf_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      evt_q   <= '0;
      ptr     <= '0;
    end else if (load) begin
      valid_q    <= 1'b1;
      evt_q.ch   <= CH_W_MAX'(sel_ch);
      evt_q.rise <= sel_rise;
      ptr        <= ptr_n;
    end else if (evt_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_ch_o    = evt_q.ch[CW-1:0];
  assign evt_rise_o  = evt_q.rise;
  assign pending_o   = rise_pend | fall_pend;
  assign overflow_o  = ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH=4): stimulus pushes expected
// events into a queue, a negedge monitor pops and compares every transfer.
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int CW     = 2;
  localparam int W      = CW + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] a_i;
  logic              en_i;
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [CW-1:0]     evt_ch_o;
  logic              evt_rise_o;
  logic [NUM_CH-1:0] pending_o;
  logic [NUM_CH-1:0] overflow_o;
  logic              ovf_clr_i;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .en_i        (en_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_ch_o    (evt_ch_o),
    .evt_rise_o  (evt_rise_o),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int ch, input logic rise);
    logic [W-1:0] e;
    e = {CW'(ch), rise};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (exp_q.size() == 0 && !evt_valid_o) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain timeout queued=%0d valid=%0b", name, exp_q.size(), evt_valid_o);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && evt_valid_o && evt_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=%0h required=none", {evt_ch_o, evt_rise_o});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({evt_ch_o, evt_rise_o} !== e) begin
          errors++;
          $display("FAIL event_order actual=%0h required=%0h", {evt_ch_o, evt_rise_o}, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; a_i = 4'b1111; en_i = 1'b1; evt_ready_i = 1'b1; ovf_clr_i = 1'b0;
    repeat (3) tick();
    check("reset_valid", evt_valid_o, 0);
    check("reset_pending", pending_o, 0);
    check("reset_overflow", overflow_o, 0);
    reset = 1'b0;

    // static level held through reset must stay silent
    for (int i = 0; i < 5; i++) begin
      tick();
      check("static_valid", evt_valid_o, 0);
      check("static_pending", pending_o, 0);
    end

    // edges with en_i=0 are dropped
    en_i = 1'b0; a_i = 4'b0000;
    tick(); tick();
    check("en_gate_pending", pending_o, 0);
    en_i = 1'b1;

    // single ch2 rise: one-cycle latency, presented for one cycle
    a_i = 4'b0100; push(2, 1'b1);
    tick();
    check("single_pending", pending_o, 4'b0100);
    check("single_valid_k", evt_valid_o, 0);
    tick();
    check("single_valid", evt_valid_o, 1);
    check("single_ch", evt_ch_o, 2);
    check("single_rise", evt_rise_o, 1);
    check("single_pending_clr", pending_o, 0);
    tick();
    check("single_valid_drop", evt_valid_o, 0);

    // ch3 rise moves ptr to 0
    a_i = 4'b1100; push(3, 1'b1);
    wait_drain("ptr_setup");
    en_i = 1'b0; a_i = 4'b0000;
    tick(); tick();
    en_i = 1'b1;
    check("rr_idle_pending", pending_o, 0);

    // all four rise together: granted 0,1,2,3 back to back
    a_i = 4'b1111;
    for (int c = 0; c < 4; c++) push(c, 1'b1);
    tick();
    check("rr_pending", pending_o, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rr_valid", evt_valid_o, 1);
      check("rr_ch", evt_ch_o, c);
    end
    tick();
    check("rr_valid_end", evt_valid_o, 0);

    // ch1 rise,fall,rise,fall with ready low
    en_i = 1'b0; a_i = 4'b1101;
    tick();
    en_i = 1'b1; evt_ready_i = 1'b0;
    a_i = 4'b1111; push(1, 1'b1); tick();
    a_i = 4'b1101; push(1, 1'b0); tick();
    check("ovf1_k2_valid", evt_valid_o, 1);
    check("ovf1_k2_ovf", overflow_o, 0);
    a_i = 4'b1111; push(1, 1'b1); tick();
    check("ovf1_k3_ovf", overflow_o, 0);
    a_i = 4'b1101; tick();
    check("ovf1_ovf", overflow_o, 4'b0010);
    check("ovf1_hold_valid", evt_valid_o, 1);
    check("ovf1_hold_ch", evt_ch_o, 1);
    check("ovf1_hold_rise", evt_rise_o, 1);
    check("ovf1_pending", pending_o, 4'b0010);
    evt_ready_i = 1'b1;
    wait_drain("ovf1_drain");

    // ch3 overflow coinciding with ovf_clr_i, then clear alone
    evt_ready_i = 1'b0; en_i = 1'b0; a_i = 4'b0101;
    tick();
    en_i = 1'b1;
    a_i = 4'b1101; push(3, 1'b1); tick();
    a_i = 4'b0101; push(3, 1'b0); tick();
    a_i = 4'b1101; push(3, 1'b1); tick();
    a_i = 4'b0101; ovf_clr_i = 1'b1; tick();
    ovf_clr_i = 1'b0;
    check("ovf3_clr_race", overflow_o, 4'b1000);
    ovf_clr_i = 1'b1; tick();
    ovf_clr_i = 1'b0;
    check("ovf_clr_alone", overflow_o, 0);
    evt_ready_i = 1'b1;
    wait_drain("ovf3_drain");

    // reset mid-transfer with three events still pending
    evt_ready_i = 1'b0;
    a_i = 4'b1010; tick();
    check("rst_pending_all", pending_o, 4'b1111);
    tick();
    check("rst_pre_valid", evt_valid_o, 1);
    check("rst_pre_ch", evt_ch_o, 0);
    check("rst_pre_rise", evt_rise_o, 0);
    check("rst_pre_pending", pending_o, 4'b1110);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", evt_valid_o, 0);
    check("rst_async_pending", pending_o, 0);
    tick();
    reset = 1'b0; evt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", evt_valid_o, 0);
      check("post_rst_pending", pending_o, 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
